// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared widths and accumulator type for the receive-side CIC decimator
package dsm_pkg;
  localparam int DATA_W = 16;
  localparam int STAGES = 3;
  localparam int LOG2_R = 3;
  localparam int ACC_W  = DATA_W + STAGES * LOG2_R;

  typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/cic_stage.sv
// rtl/cic_stage.sv - one CIC integrator register plus one comb delay register
module cic_stage
  import dsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_integ_en,
  input  logic i_comb_en,
  input  acc_t i_integ,
  output acc_t o_integ,
  input  acc_t i_comb,
  output acc_t o_comb
);

  acc_t r_integ;
  acc_t r_dly;

  // Integrator and comb both wrap modulo 2^ACC_W; the comb differences
  // cancel the wrap exactly, so no saturation is wanted here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_integ <= '0;
      r_dly   <= '0;
    end else begin
      if (i_integ_en) r_integ <= r_integ + i_integ;
      if (i_comb_en)  r_dly   <= i_comb;
    end
  end

  assign o_integ = r_integ;
  assign o_comb  = i_comb - r_dly;

endmodule

// File: rtl/cic8_decim.sv
// rtl/cic8_decim.sv - 3-stage R=8 M=1 CIC decimator with clk_enable/ce_out handshake
module cic8_decim
  import dsm_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] filter_in,
  output logic signed [DATA_W-1:0] filter_out,
  output logic                     ce_out
);

  localparam int SHIFT = ACC_W - DATA_W;

  acc_t w_integ [0:STAGES];
  acc_t w_comb  [0:STAGES];
  acc_t w_scaled;
  logic w_strobe;

  logic [LOG2_R-1:0]        r_phase;
  logic signed [DATA_W-1:0] r_filter_out;
  logic                     r_ce_out;

  assign w_integ[0] = {{SHIFT{filter_in[DATA_W-1]}}, filter_in};
  assign w_comb[0]  = w_integ[STAGES];
  assign w_strobe   = clk_enable & (r_phase == {LOG2_R{1'b1}});

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cic_stage u_stage (
      .clk        (clk),
      .reset      (reset),
      .i_integ_en (clk_enable),
      .i_comb_en  (w_strobe),
      .i_integ    (w_integ[g]),
      .o_integ    (w_integ[g+1]),
      .i_comb     (w_comb[g]),
      .o_comb     (w_comb[g+1])
    );
  end

  // DC gain is exactly 2^SHIFT, so an arithmetic shift is the whole scaling.
  assign w_scaled = w_comb[STAGES] >>> SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= '0;
      r_filter_out <= '0;
      r_ce_out     <= 1'b0;
    end else begin
      r_ce_out <= w_strobe;
      if (clk_enable) r_phase <= r_phase + {{(LOG2_R-1){1'b0}}, 1'b1};
      if (w_strobe)   r_filter_out <= DATA_W'(w_scaled);
    end
  end

  assign filter_out = r_filter_out;
  assign ce_out     = r_ce_out;

endmodule
